// File: rtl/analyzer_pkg.sv
// Shared types and constants for the FFT-to-Analyzer frame scheduler.
// Bin geometry is fixed by the 16-bin peak Analyzer.
package analyzer_pkg;

    localparam int DW           = 32;
    localparam int NBIN         = 16;
    localparam int FREQ_W       = 4;
    localparam int SEQ_W        = 8;
    localparam int ANALYZER_LAT = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

endpackage

// File: rtl/analyzer_frame_sched_frame_fifo.sv
// Register FIFO holding whole frames plus their sequence tags.
// Head entry is always visible; push and pop are pre-qualified by the caller.
module frame_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/analyzer_frame_sched.sv
// Buffers FFT frames, issues them one at a time to the peak Analyzer,
// and returns the winning bin with the frame's sequence tag.
module analyzer_frame_sched
    import analyzer_pkg::*;
#(
    parameter int DW      = 32,
    parameter int NBIN    = 16,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NBIN*DW-1:0]   in_frame,
    output logic                 az_valid,
    output logic [NBIN*DW-1:0]   az_d,
    input  logic                 az_done,
    input  logic [FREQ_W-1:0]    az_freq,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FREQ_W-1:0]    out_freq,
    output logic [SEQ_W-1:0]     out_seq,
    output logic                 err_timeout,
    output logic                 busy
);

    localparam int FW = NBIN * DW;
    localparam int EW = FW + SEQ_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [3:0] TO = 4'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wait_cnt;
    logic [3:0]       wait_nxt;
    logic [SEQ_W-1:0] seq;
    logic             push;
    logic             pop;
    logic             load;
    logic             abort;
    logic [EW-1:0]    head;
    logic [SEQ_W-1:0] head_seq;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && !full;
    assign az_d     = head[EW-1:SEQ_W];
    assign head_seq = head[SEQ_W-1:0];
    assign busy     = (state != IDLE) || !empty;

    frame_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_frame, seq}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        pop       = 1'b0;
        load      = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                // Only issue when the result slot is free or draining now.
                if (!empty && (!out_valid || out_ready)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                wait_nxt  = '0;
            end
            WAIT: begin
                wait_nxt = wait_cnt + 4'd1;
                if (az_done) begin
                    load      = 1'b1;
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_nxt == TO) begin
                    abort     = 1'b1;
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            seq         <= '0;
            az_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_freq    <= '0;
            out_seq     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            az_valid <= (state_nxt == ISSUE);
            if (push) begin
                seq <= seq + SEQ_W'(1);
            end
            if (load) begin
                out_valid <= 1'b1;
                out_freq  <= az_freq;
                out_seq   <= head_seq;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (abort) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/analyzer_frame_sched.md
Name: analyzer_frame_sched

Overview:
Scheduler between the FFT output stage and the 16-bin peak Analyzer.
- Buffers whole 16-bin frames arriving on a valid/ready handshake.
- Issues one frame at a time to the Analyzer: single-cycle fft_valid, data held stable until done.
- Captures the winning bin index and presents it downstream on a valid/ready handshake with a frame sequence tag.
- Guards against a hung Analyzer with a timeout.

Parameters:
DW, 32, bit width of one FFT bin
NBIN, 16, bins per frame (fixed by the Analyzer; not to be changed)
DEPTH, 2, frame buffer slots (power of 2, >=2)
TIMEOUT, 15, max cycles in WAIT before abort (4-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream frame valid
in_ready  out  1  frame buffer can accept; = (count < DEPTH)
in_frame  in  NBIN*DW  bins packed; bin k at [k*DW +: DW]
az_valid  out  1  to Analyzer fft_valid; registered single-cycle pulse
az_d  out  NBIN*DW  to Analyzer fft_d0..fft_d15; head slot of buffer
az_done  in  1  Analyzer done
az_freq  in  4  Analyzer freq (meaningful only while az_done=1)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_freq  out  4  winning bin index
out_seq  out  8  sequence tag of the frame that produced out_freq
err_timeout  out  1  sticky; set when a frame is aborted
busy  out  1  high when state != IDLE or count != 0

Behaviour:
Reset values (asynchronous):
- az_valid=0, out_valid=0, out_freq=0, out_seq=0, err_timeout=0.
- FIFO count=0 and pointers=0; in-sequence counter=0; state=IDLE.

Push:
- in_valid && in_ready at an edge writes {in_frame, seq} to the tail and increments seq (8-bit, 255 wraps to 0).
- No pass-through. When full, in_ready=0 even if a pop occurs in the same cycle.

FSM (IDLE, ISSUE, WAIT):
- IDLE -> ISSUE when count!=0 && (!out_valid || out_ready). The result slot must be free or draining this cycle.
- ISSUE: az_valid=1 for exactly this one cycle. Next state is WAIT, with wait counter cleared.
- WAIT: az_valid=0; wait counter increments each cycle.
  - az_done=1: out_freq<=az_freq, out_seq<=head seq, out_valid<=1. Pop head, go to IDLE.
  - Counter reaches TIMEOUT without done: err_timeout<=1, pop head, no result, go to IDLE.
- az_d is driven from the head slot in every state and must stay stable from ISSUE through the WAIT exit.

Latency:
- Analyzer done arrives 4 cycles after the fft_valid pulse.
- Frame accepted at edge N into an empty buffer in IDLE: ISSUE in cycle N+1, az_done in N+5, out_valid in N+6.
- Back-to-back issue interval is 6 cycles per frame.

Output handshake:
- out_valid is held, with out_freq and out_seq stable, until out_ready.
- out_valid clears on acceptance unless a new result loads in the same cycle. That load is legal only when acceptance occurs in that cycle.

Boundary conditions:
- az_done while not in WAIT: ignored.
- az_done in the same cycle the counter hits TIMEOUT: done wins and there is no error.
- Push and pop in the same cycle with 0 < count < DEPTH: count is unchanged.
- Pointers wrap modulo DEPTH.
- Reset mid-WAIT: everything clears. The Analyzer shares rst, so no stale done is expected.
- err_timeout clears only on rst.

Decomposition:
- Shared package analyzer_pkg:
  - DW, NBIN, FREQ_W=4, SEQ_W=8
  - state enum {IDLE, ISSUE, WAIT}
  - ANALYZER_LAT=4
- One sub-module, frame_fifo: DEPTH-entry register FIFO of width NBIN*DW+SEQ_W, with push, pop, head data, count, full and empty.
- FSM, wait counter and result register stay in the top.

Test Plan:
1. Reset, then one frame with bin 9 = 0x0000_0100 and all others 0x10 (Analyzer model attached) -> az_valid pulse in cycle N+1; out_valid in N+6 with out_freq=9, out_seq=0.
2. Three frames back-to-back with peaks at 3, 12, 0 and out_ready=1 -> in_ready drops after 2 accepts; results 3, 12, 0 with seq 0, 1, 2, spaced 6 cycles apart.
3. out_ready held 0 for 20 cycles during a 2-frame burst -> the second ISSUE is withheld; out_valid/out_freq stay stable; both results arrive in order once out_ready=1.
4. Analyzer model never raises done -> abort after 15 WAIT cycles; err_timeout=1 (sticky); no out_valid; the next frame issues normally.
5. Spurious az_done pulse in IDLE -> no out_valid, FIFO count unchanged.
6. rst asserted mid-WAIT with 2 frames buffered -> all outputs return to reset values immediately; in_ready=1; the next frame is tagged seq=0.
